// File: rtl/dcache_pkg.sv
// ============================================================================
// Module      : dcache_pkg
// Description : Shared defaults, refill FSM encoding and address-split helpers
//               for the data/instruction cache refill controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int INDEX_W    = 7;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int TAG_W      = ADDR_W - INDEX_W - OFF_W - 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_FILL   = 3'd2,
    ST_LAST   = 3'd3,
    ST_COMMIT = 3'd4
  } refill_state_t;

  // Address layout: | tag | index | word offset | byte offset (2) |
  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W+2 +: INDEX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[2 +: OFF_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_refill_ctrl_beat_counter.sv
// ============================================================================
// Module      : refill_beat_counter
// Description : Wrapping beat counter with start-offset load and a count of
//               beats still to be accepted for the current line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module refill_beat_counter #(
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [OFF_W-1:0] start_i,
  input  logic             step_i,
  output logic [OFF_W-1:0] count_o,
  output logic [OFF_W:0]   remaining_o,
  output logic             last_o
);

  localparam logic [OFF_W:0] LINE_BEATS = (OFF_W+1)'(LINE_WORDS);

  logic [OFF_W-1:0] count_q;
  logic [OFF_W:0]   remaining_q;

  // LINE_WORDS is a power of two, so the word counter wraps by overflow.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q     <= '0;
      remaining_q <= '0;
    end else if (load_i) begin
      count_q     <= start_i;
      remaining_q <= LINE_BEATS;
    end else if (step_i && (remaining_q != '0)) begin
      count_q     <= count_q + 1'b1;
      remaining_q <= remaining_q - 1'b1;
    end
  end

  assign count_o     = count_q;
  assign remaining_o = remaining_q;
  assign last_o      = (remaining_q == (OFF_W+1)'(1));

endmodule

`default_nettype wire

// File: rtl/dcache_refill_ctrl.sv
// ============================================================================
// Module      : dcache_refill_ctrl
// Description : Data cache line-refill controller: request line, write beats
//               to the data RAM, then commit tag and valid bit.
//               Optional build macro: DCACHE_CRITICAL_WORD_FIRST_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_refill_ctrl #(
  parameter int ADDR_W     = dcache_pkg::ADDR_W,
  parameter int DATA_W     = dcache_pkg::DATA_W,
  parameter int INDEX_W    = dcache_pkg::INDEX_W,
  parameter int LINE_WORDS = dcache_pkg::LINE_WORDS,
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = ADDR_W - INDEX_W - OFF_W - 2
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               MissReq,
  input  logic [ADDR_W-1:0]  MissAddr,
  output logic               Busy,
  output logic               MemReq,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic               MemAck,
  input  logic               MemRdValid,
  input  logic [DATA_W-1:0]  MemRdData,
  output logic               DataWrite,
  output logic [INDEX_W-1:0] DataIndex,
  output logic [OFF_W-1:0]   DataWordSel,
  output logic [DATA_W-1:0]  DataWriteData,
  output logic               TagWrite,
  output logic [TAG_W-1:0]   TagData,
  output logic               WriteValid,
  output logic [INDEX_W-1:0] CacheIndexWrite,
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  output logic               CritValid,
  output logic [DATA_W-1:0]  CritData,
`endif
  output logic               RefillDone
);

  import dcache_pkg::*;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  localparam int ADDR_LSB = 2;
`else
  localparam int ADDR_LSB = OFF_W + 2;
`endif

  refill_state_t state_q, state_d;

  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;

  logic               busy_q, mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               data_write_q;
  logic [INDEX_W-1:0] data_index_q;
  logic [OFF_W-1:0]   data_word_sel_q;
  logic [DATA_W-1:0]  data_write_data_q;
  logic               tag_write_q, write_valid_q, refill_done_q;
  logic [TAG_W-1:0]   tag_data_q;
  logic [INDEX_W-1:0] cache_index_write_q;

  logic               w_miss_go, w_ack_go, w_beat, w_commit;
  logic [OFF_W-1:0]   w_start, w_count;
  logic [OFF_W:0]     w_remaining;
  logic               w_last;
  logic [ADDR_W-1:0]  w_req_addr;
  logic               w_unused;

  assign w_miss_go  = (state_q == ST_IDLE) && MissReq;
  assign w_ack_go   = (state_q == ST_REQ)  && MemAck;
  assign w_beat     = (state_q == ST_FILL) && MemRdValid;
  assign w_commit   = (state_q == ST_LAST);
  assign w_req_addr = {MissAddr[ADDR_W-1:ADDR_LSB], {ADDR_LSB{1'b0}}};

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]  off_q;
  logic              first_q;
  logic              crit_valid_q;
  logic [DATA_W-1:0] crit_data_q;

  // The first beat of a wrapped burst is the word the core is waiting on.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      off_q        <= '0;
      first_q      <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      if (w_miss_go) off_q <= MissAddr[2 +: OFF_W];
      if (w_ack_go) first_q <= 1'b1;
      else if (w_beat) first_q <= 1'b0;
      crit_valid_q <= w_beat && first_q;
      if (w_beat && first_q) crit_data_q <= MemRdData;
    end
  end

  assign w_start   = off_q;
  assign CritValid = crit_valid_q;
  assign CritData  = crit_data_q;
  assign w_unused  = ^{MissAddr[1:0], w_remaining};
`else
  assign w_start   = '0;
  assign w_unused  = ^{MissAddr[OFF_W+1:0], w_remaining};
`endif

  refill_beat_counter #(
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OFF_W)
  ) u_beat_cnt (
    .clk         (clk),
    .Reset       (Reset),
    .load_i      (w_ack_go),
    .start_i     (w_start),
    .step_i      (w_beat),
    .count_o     (w_count),
    .remaining_o (w_remaining),
    .last_o      (w_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (MissReq) state_d = ST_REQ;
      ST_REQ:    if (MemAck) state_d = ST_FILL;
      ST_FILL:   if (MemRdValid && w_last) state_d = ST_LAST;
      ST_LAST:   state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q             <= ST_IDLE;
      tag_q               <= '0;
      index_q             <= '0;
      busy_q              <= 1'b0;
      mem_req_q           <= 1'b0;
      mem_addr_q          <= '0;
      data_write_q        <= 1'b0;
      data_index_q        <= '0;
      data_word_sel_q     <= '0;
      data_write_data_q   <= '0;
      tag_write_q         <= 1'b0;
      write_valid_q       <= 1'b0;
      refill_done_q       <= 1'b0;
      tag_data_q          <= '0;
      cache_index_write_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != ST_IDLE);
      mem_req_q <= (state_d == ST_REQ);

      if (w_miss_go) begin
        tag_q      <= MissAddr[ADDR_W-1 -: TAG_W];
        index_q    <= MissAddr[OFF_W+2 +: INDEX_W];
        mem_addr_q <= w_req_addr;
      end

      data_write_q <= w_beat;
      if (w_beat) begin
        data_index_q      <= index_q;
        data_word_sel_q   <= w_count;
        data_write_data_q <= MemRdData;
      end

      // Commit is raised only after the final DataWrite has been presented.
      tag_write_q   <= w_commit;
      write_valid_q <= w_commit;
      refill_done_q <= w_commit;
      if (w_commit) begin
        tag_data_q          <= tag_q;
        cache_index_write_q <= index_q;
      end
    end
  end

  assign Busy            = busy_q;
  assign MemReq          = mem_req_q;
  assign MemAddr         = mem_addr_q;
  assign DataWrite       = data_write_q;
  assign DataIndex       = data_index_q;
  assign DataWordSel     = data_word_sel_q;
  assign DataWriteData   = data_write_data_q;
  assign TagWrite        = tag_write_q;
  assign TagData         = tag_data_q;
  assign WriteValid      = write_valid_q;
  assign CacheIndexWrite = cache_index_write_q;
  assign RefillDone      = refill_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_refill_ctrl.sv
// ============================================================================
// Module      : tb_dcache_refill_ctrl
// Description : Scoreboard bench for dcache_refill_ctrl (data writes + commits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 7;
  localparam int LW = 4;
  localparam int OW = 2;
  localparam int TW = AW - IW - OW - 2;

  logic          clk = 1'b0;
  logic          Reset;
  logic          MissReq;
  logic [AW-1:0] MissAddr;
  logic          Busy, MemReq;
  logic [AW-1:0] MemAddr;
  logic          MemAck, MemRdValid;
  logic [DW-1:0] MemRdData;
  logic          DataWrite;
  logic [IW-1:0] DataIndex;
  logic [OW-1:0] DataWordSel;
  logic [DW-1:0] DataWriteData;
  logic          TagWrite;
  logic [TW-1:0] TagData;
  logic          WriteValid;
  logic [IW-1:0] CacheIndexWrite;
  logic          RefillDone;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic          CritValid;
  logic [DW-1:0] CritData;
  bit            first_pending = 1'b0;
`endif

  always #5 clk = ~clk;

  dcache_refill_ctrl dut (
    .clk             (clk),
    .Reset           (Reset),
    .MissReq         (MissReq),
    .MissAddr        (MissAddr),
    .Busy            (Busy),
    .MemReq          (MemReq),
    .MemAddr         (MemAddr),
    .MemAck          (MemAck),
    .MemRdValid      (MemRdValid),
    .MemRdData       (MemRdData),
    .DataWrite       (DataWrite),
    .DataIndex       (DataIndex),
    .DataWordSel     (DataWordSel),
    .DataWriteData   (DataWriteData),
    .TagWrite        (TagWrite),
    .TagData         (TagData),
    .WriteValid      (WriteValid),
    .CacheIndexWrite (CacheIndexWrite),
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    .CritValid       (CritValid),
    .CritData        (CritData),
`endif
    .RefillDone      (RefillDone)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int dw_since = 0;

  // Expected data writes {index, word, data} and commits {index, tag}
  logic [IW+OW+DW-1:0] dwq[$];
  logic [IW+TW-1:0]    cmq[$];
  logic [IW+OW+DW-1:0] mon_e;
  logic [IW+TW-1:0]    mon_c;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Reset) begin
      dw_since = 0;
    end else begin
      if (DataWrite) begin
        check_eq("dw_expected", dwq.size() != 0, 1);
        if (dwq.size() != 0) begin
          mon_e = dwq.pop_front();
          check_eq("dw_index", DataIndex, mon_e[OW+DW +: IW]);
          check_eq("dw_word", DataWordSel, mon_e[DW +: OW]);
          check_eq("dw_data", DataWriteData, mon_e[DW-1:0]);
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
          check_eq("crit_valid", CritValid, first_pending);
          if (first_pending) check_eq("crit_data", CritData, mon_e[DW-1:0]);
          first_pending = 1'b0;
`endif
        end
        dw_since++;
      end
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      else if (CritValid) check_eq("crit_stray", CritValid, 0);
`endif
      if (WriteValid || TagWrite || RefillDone) begin
        check_eq("commit_expected", cmq.size() != 0, 1);
        check_eq("commit_valid", WriteValid, 1);
        check_eq("commit_tagwr", TagWrite, 1);
        check_eq("commit_done", RefillDone, 1);
        check_eq("commit_after_words", dw_since, LW);
        if (cmq.size() != 0) begin
          mon_c = cmq.pop_front();
          check_eq("commit_index", CacheIndexWrite, mon_c[TW +: IW]);
          check_eq("commit_tag", TagData, mon_c[TW-1:0]);
        end
        dw_since = 0;
      end
    end
  end

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_busy"}, Busy, 0);
    check_eq({pfx, "_memreq"}, MemReq, 0);
    check_eq({pfx, "_memaddr"}, MemAddr, 0);
    check_eq({pfx, "_dw"}, DataWrite, 0);
    check_eq({pfx, "_dindex"}, DataIndex, 0);
    check_eq({pfx, "_dsel"}, DataWordSel, 0);
    check_eq({pfx, "_ddata"}, DataWriteData, 0);
    check_eq({pfx, "_tagwr"}, TagWrite, 0);
    check_eq({pfx, "_tagdata"}, TagData, 0);
    check_eq({pfx, "_wvalid"}, WriteValid, 0);
    check_eq({pfx, "_cidx"}, CacheIndexWrite, 0);
    check_eq({pfx, "_done"}, RefillDone, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MissReq = 1'b0;
      @(negedge clk);
      check_eq("idle_busy", Busy, 0);
      @(posedge clk); #1;
    end
  endtask

  // Entered and left at posedge+1; returns in the first IDLE cycle after commit.
  task automatic do_refill(input logic [AW-1:0] addr, input int ack_dly, input int gap_max,
                           input bit hold, input bit stray, input int abort_after);
    logic [IW-1:0] idx;
    logic [TW-1:0] tg;
    logic [OW-1:0] start, w;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] d;
    int            gaps;
    idx = addr[OW+2 +: IW];
    tg  = addr[AW-1 -: TW];
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    start    = addr[2 +: OW];
    exp_addr = {addr[AW-1:2], 2'b00};
`else
    start    = '0;
    exp_addr = {addr[AW-1:OW+2], {(OW+2){1'b0}}};
`endif
    MissReq  = 1'b1;
    MissAddr = addr;
    cmq.push_back({idx, tg});
    @(negedge clk);
    check_eq("busy_before_req", Busy, 0);
    @(posedge clk); #1;
    MissReq  = hold;
    MissAddr = 32'hDEAD_BEE0;
    for (int c = 0; c <= ack_dly; c++) begin
      MemAck     = (c == ack_dly);
      MemRdValid = stray;
      MemRdData  = 32'hBAD0_0000 + c;
      @(negedge clk);
      check_eq("req_memreq", MemReq, 1);
      check_eq("req_busy", Busy, 1);
      check_eq("req_memaddr", MemAddr, exp_addr);
      @(posedge clk); #1;
    end
    MemAck     = 1'b0;
    MemRdValid = 1'b0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    first_pending = 1'b1;
`endif
    for (int k = 0; k < LW; k++) begin
      if (k == abort_after) begin
        @(negedge clk);
        #2;
        Reset   = 1'b1;
        MissReq = 1'b0;
        #1;
        check_zero("abort");
        dwq.delete();
        cmq.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        check_eq("abort_no_valid", WriteValid, 0);
        @(posedge clk); #1;
        return;
      end
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        MemRdValid = 1'b0;
        @(negedge clk);
        check_eq("fill_memreq", MemReq, 0);
        @(posedge clk); #1;
      end
      d = $urandom;
      w = start + OW'(k);
      MemRdValid = 1'b1;
      MemRdData  = d;
      dwq.push_back({idx, w, d});
      @(negedge clk);
      check_eq("beat_memreq", MemReq, 0);
      check_eq("beat_busy", Busy, 1);
      @(posedge clk); #1;
    end
    MemRdValid = stray;
    MemRdData  = 32'hBAD1_0000;
    MissReq    = 1'b0;
    @(negedge clk);
    check_eq("busy_last", Busy, 1);
    @(posedge clk); #1;
    MemRdValid = 1'b0;
    @(negedge clk);
    check_eq("busy_commit", Busy, 1);
    check_eq("commit_cycle", WriteValid, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    MissReq    = 1'b0;
    MissAddr   = '0;
    MemAck     = 1'b0;
    MemRdValid = 1'b0;
    MemRdData  = '0;
    @(posedge clk); #3;
    check_zero("rst");
    @(posedge clk); #1;
    Reset = 1'b0;
    idle(2);

    do_refill(32'h0000_1234, 2, 0, 1'b0, 1'b0, -1);
    idle(3);
    do_refill(32'h0000_1234, 1, 3, 1'b0, 1'b0, -1);
    do_refill(32'h0000_1234, 0, 3, 1'b0, 1'b0, -1);
    idle(2);
    do_refill(32'h0000_5678, 2, 1, 1'b1, 1'b1, -1);
    idle(2);
    do_refill(32'h0000_9AB0, 1, 0, 1'b0, 1'b0, 2);
    idle(1);
    do_refill(32'h0000_9AB4, 0, 2, 1'b0, 1'b0, -1);
    idle(2);
    do_refill(32'hABCD_07F8, 1, 0, 1'b0, 1'b0, -1);
    do_refill(32'h1357_8804, 1, 0, 1'b0, 1'b0, -1);
    idle(2);
    do_refill(32'h0000_2348, 1, 1, 1'b0, 1'b0, -1);
    idle(2);

    check_eq("dwq_drained", dwq.size(), 0);
    check_eq("cmq_drained", cmq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
